fetch_stage: RTL and testbench

- PC register plus IF/ID pipeline register. Sits directly upstream of the instruction memory: drives its byte-address pc and consumes the instruction it returns in the same cycle (combinational read).
- Registers the fetched instruction with its PC+4 into IF/ID for the decode stage.
- Handles pipeline stall (hold) and branch/jump redirect (PC reload plus flush of the wrong-path fetch).

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: PC register and IF/ID pipeline register with stall and redirect.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef FETCH_PERF_CNT_EN
  ,
  parameter int          PERF_W    = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_fetch_count,
  output logic [PERF_W-1:0] perf_stall_count
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        advance;
  logic        holding;

  // Redirect beats stall: the redirecting branch is older than the stalled instruction.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    advance = 1'b0;
    holding = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_target & 32'hFFFF_FFFC;
      instr_d = NOP_INSTR;
      pcp4_d  = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (stall) begin
      holding = 1'b1;
    end else begin
      advance = 1'b1;
      pc_d    = pc_q + 32'd4;
      instr_d = imem_instruction;
      pcp4_d  = pc_q + 32'd4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp4_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_pc           = pc_q;
  assign if_id_instruction = instr_q;
  assign if_id_pc_plus4    = pcp4_q;
  assign if_id_valid       = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  // Both counters wrap freely; no saturation.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (advance) fetch_cnt_d = fetch_cnt_q + 1'b1;
    if (holding) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_count = fetch_cnt_q;
  assign perf_stall_count = stall_cnt_q;
`else
  logic unused_flags;
  assign unused_flags = advance ^ holding;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect/reset traffic checked against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_pc, imem_instruction, if_id_instruction, if_id_pc_plus4;
  logic        if_id_valid;

  logic        wRst_n, wStall, wRedirect;
  logic [31:0] wTarget;
  logic [31:0] wImemPc, wImemInstr, wInstr, wPcp4;
  logic        wValid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_count, perf_stall_count;
  logic [31:0] wPerfFetch, wPerfStall;
`endif

  int nChecks = 0;
  int nFail   = 0;

  // Behavioural model of the fetch stage's architectural state
  logic [31:0] mPc, mInstr, mPcp4, mFetch, mStallCnt;
  logic        mValid;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0001;
      32'h4:   return 32'h2009_0002;
      32'h8:   return 32'h0109_5020;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign imem_instruction = memWord(imem_pc);
  assign wImemInstr       = memWord(wImemPc);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_pc(imem_pc),
    .imem_instruction(imem_instruction), .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_count(perf_fetch_count), .perf_stall_count(perf_stall_count)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst_n(wRst_n), .stall(wStall), .redirect_valid(wRedirect),
    .redirect_target(wTarget), .imem_pc(wImemPc),
    .imem_instruction(wImemInstr), .if_id_instruction(wInstr),
    .if_id_pc_plus4(wPcp4), .if_id_valid(wValid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_count(wPerfFetch), .perf_stall_count(wPerfStall)
`endif
  );

  // Advance the model by the rules for the inputs now applied, then clock the DUT.
  task automatic tick();
    if (!rst_n) begin
      mPc = 32'h0; mInstr = 32'h0; mPcp4 = 32'h0; mValid = 1'b0;
      mFetch = 32'h0; mStallCnt = 32'h0;
    end else if (redirect_valid) begin
      mPc = {redirect_target[31:2], 2'b00};
      mInstr = 32'h0; mPcp4 = 32'h0; mValid = 1'b0;
    end else if (stall) begin
      mStallCnt = mStallCnt + 1;
    end else begin
      mInstr = memWord(mPc); mPcp4 = mPc + 4; mValid = 1'b1;
      mPc = mPc + 4; mFetch = mFetch + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    wRst_n = 1'b0; wStall = 1'b0; wRedirect = 1'b0; wTarget = 32'h0;
    tick(); tick();
    nChecks++; if (imem_pc !== 32'h0) begin nFail++; $display("FAIL reset_pc: got %h want %h", imem_pc, 32'h0); end
    nChecks++; if (if_id_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    nChecks++; if (if_id_instruction !== 32'h0) begin nFail++; $display("FAIL reset_instr: got %h want 0", if_id_instruction); end
    nChecks++; if (if_id_pc_plus4 !== 32'h0) begin nFail++; $display("FAIL reset_pcp4: got %h want 0", if_id_pc_plus4); end
    nChecks++; if (wImemPc !== 32'hFFFF_FFFC) begin nFail++; $display("FAIL reset_wrap_pc: got %h want fffffffc", wImemPc); end
  endtask

  task automatic test_free_run_and_stall();
    rst_n = 1'b1;
    tick();
    nChecks++; if (imem_pc !== 32'h4) begin nFail++; $display("FAIL run_pc1: got %h want 4", imem_pc); end
    nChecks++; if (if_id_instruction !== 32'h2008_0001 || if_id_pc_plus4 !== 32'h4 || if_id_valid !== 1'b1) begin
      nFail++; $display("FAIL run_ifid1: got %h/%h/%b want 20080001/4/1", if_id_instruction, if_id_pc_plus4, if_id_valid); end
    tick();
    nChecks++; if (imem_pc !== 32'h8) begin nFail++; $display("FAIL run_pc2: got %h want 8", imem_pc); end
    nChecks++; if (if_id_instruction !== 32'h2009_0002 || if_id_pc_plus4 !== 32'h8) begin
      nFail++; $display("FAIL run_ifid2: got %h/%h want 20090002/8", if_id_instruction, if_id_pc_plus4); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++; if (imem_pc !== 32'h8 || if_id_instruction !== 32'h2009_0002 || if_id_pc_plus4 !== 32'h8 || if_id_valid !== 1'b1) begin
        nFail++; $display("FAIL stall_hold%0d: got %h %h/%h/%b want 8 20090002/8/1", i, imem_pc, if_id_instruction, if_id_pc_plus4, if_id_valid); end
    end
    stall = 1'b0;
    tick();
    nChecks++; if (imem_pc !== 32'hC || if_id_instruction !== 32'h0109_5020 || if_id_pc_plus4 !== 32'hC) begin
      nFail++; $display("FAIL stall_resume: got %h %h/%h want c 01095020/c", imem_pc, if_id_instruction, if_id_pc_plus4); end
  endtask

  task automatic test_redirect();
    tick();
    nChecks++; if (imem_pc !== 32'h10) begin nFail++; $display("FAIL redir_setup: got %h want 10", imem_pc); end
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    nChecks++; if (imem_pc !== 32'h40 || if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin
      nFail++; $display("FAIL redir_bubble: got %h %b %h %h want 40 0 0 0", imem_pc, if_id_valid, if_id_instruction, if_id_pc_plus4); end
    redirect_valid = 1'b0;
    tick();
    nChecks++; if (if_id_instruction !== memWord(32'h40) || if_id_pc_plus4 !== 32'h44 || if_id_valid !== 1'b1) begin
      nFail++; $display("FAIL redir_target: got %h/%h/%b want %h/44/1", if_id_instruction, if_id_pc_plus4, if_id_valid, memWord(32'h40)); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h23;
    tick();
    nChecks++; if (imem_pc !== 32'h20 || if_id_valid !== 1'b0 || if_id_instruction !== 32'h0) begin
      nFail++; $display("FAIL redir_stall: got %h %b %h want 20 0 0", imem_pc, if_id_valid, if_id_instruction); end
    redirect_valid = 1'b0;
    tick();
    nChecks++; if (imem_pc !== 32'h20 || if_id_valid !== 1'b0) begin
      nFail++; $display("FAIL bubble_stall: got %h %b want 20 0", imem_pc, if_id_valid); end
    stall = 1'b0;
    tick();
    nChecks++; if (imem_pc !== 32'h24 || if_id_instruction !== memWord(32'h20) || if_id_pc_plus4 !== 32'h24) begin
      nFail++; $display("FAIL redir_stall_resume: got %h %h/%h want 24 %h/24", imem_pc, if_id_instruction, if_id_pc_plus4, memWord(32'h20)); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1; redirect_target = 32'h100;
    tick();
    redirect_target = 32'h202;
    tick();
    nChecks++; if (imem_pc !== 32'h200 || if_id_valid !== 1'b0) begin
      nFail++; $display("FAIL b2b_redir: got %h %b want 200 0", imem_pc, if_id_valid); end
    redirect_target = imem_pc;
    tick();
    nChecks++; if (imem_pc !== 32'h200 || if_id_valid !== 1'b0) begin
      nFail++; $display("FAIL self_redir: got %h %b want 200 0", imem_pc, if_id_valid); end
    redirect_valid = 1'b0;
    tick();
    nChecks++; if (if_id_instruction !== memWord(32'h200) || if_id_pc_plus4 !== 32'h204 || if_id_valid !== 1'b1) begin
      nFail++; $display("FAIL b2b_target: got %h/%h/%b want %h/204/1", if_id_instruction, if_id_pc_plus4, if_id_valid, memWord(32'h200)); end
  endtask

  task automatic test_wrap_and_reset();
    wRst_n = 1'b1;
    tick();
    nChecks++; if (wImemPc !== 32'h0 || wPcp4 !== 32'h0 || wValid !== 1'b1 || wInstr !== memWord(32'hFFFF_FFFC)) begin
      nFail++; $display("FAIL wrap_adv: got %h %h %b %h want 0 0 1 %h", wImemPc, wPcp4, wValid, wInstr, memWord(32'hFFFF_FFFC)); end
    tick();
    nChecks++; if (wImemPc !== 32'h4 || wPcp4 !== 32'h4) begin
      nFail++; $display("FAIL wrap_adv2: got %h %h want 4 4", wImemPc, wPcp4); end
    wRst_n = 1'b0;
    tick();
    nChecks++; if (wImemPc !== 32'hFFFF_FFFC || wValid !== 1'b0) begin
      nFail++; $display("FAIL wrap_reset: got %h %b want fffffffc 0", wImemPc, wValid); end
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80; rst_n = 1'b0;
    tick();
    nChecks++; if (imem_pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc_plus4 !== 32'h0) begin
      nFail++; $display("FAIL reset_over_redir: got %h %b %h want 0 0 0", imem_pc, if_id_valid, if_id_pc_plus4); end
    stall = 1'b0; redirect_valid = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n           = ($urandom_range(0, 63) != 0);
      stall           = ($urandom_range(0, 3) == 0);
      redirect_valid  = ($urandom_range(0, 7) == 0);
      redirect_target = $urandom_range(0, 3) == 0 ? $urandom : {20'h0, 12'($urandom)};
      tick();
      nChecks++; if (imem_pc !== mPc) begin nFail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, imem_pc, mPc); end
      nChecks++; if (if_id_valid !== mValid || if_id_instruction !== mInstr || if_id_pc_plus4 !== mPcp4) begin
        nFail++; $display("FAIL rnd_ifid[%0d]: got %b/%h/%h want %b/%h/%h", i, if_id_valid, if_id_instruction, if_id_pc_plus4, mValid, mInstr, mPcp4); end
`ifdef FETCH_PERF_CNT_EN
      nChecks++; if (perf_fetch_count !== mFetch || perf_stall_count !== mStallCnt) begin
        nFail++; $display("FAIL rnd_perf[%0d]: got %0d/%0d want %0d/%0d", i, perf_fetch_count, perf_stall_count, mFetch, mStallCnt); end
`endif
    end
    rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0;
    tick();
    nChecks++; if (perf_fetch_count !== 32'h0 || perf_stall_count !== 32'h0) begin
      nFail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_fetch_count, perf_stall_count); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    stall = 1'b1;
    tick(); tick();
    stall = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    nChecks++; if (perf_fetch_count !== 32'd5 || perf_stall_count !== 32'd2) begin
      nFail++; $display("FAIL perf_counts: got %0d/%0d want 5/2", perf_fetch_count, perf_stall_count); end
    rst_n = 1'b0;
    tick();
    nChecks++; if (perf_fetch_count !== 32'h0 || perf_stall_count !== 32'h0) begin
      nFail++; $display("FAIL perf_clear: got %0d/%0d want 0/0", perf_fetch_count, perf_stall_count); end
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_free_run_and_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_wrap_and_reset();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
